rr_arb8_ctrl: RTL and testbench

Eight-way round-robin arbiter that shares one resource among eight requesters and drives a registered one-hot grant vector from a 3-bit grant index (3-to-8 decode). Sits in front of the shared datapath. A requester holds its grant until it signals completion, drops its request or hits a programmable hold limit. Fairness is rotating priority starting one past the last-served requester.

---
 rtl/rr_arb8_ctrl_if.sv | 28 ++
 rtl/rr_arb8_ctrl.sv | 106 ++++++++++
 tb/tb_rr_arb8_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rr_arb8_ctrl_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
interface rr_arb8_ctrl_if;
  logic [7:0] Req;
  logic       Done;
  logic [7:0] Grant;
  logic [2:0] Grant_idx;
  logic       Grant_vld;
  logic       Expired;

  modport slave (
    input  Req,
    input  Done,
    output Grant,
    output Grant_idx,
    output Grant_vld,
    output Expired
  );

  modport master (
    output Req,
    output Done,
    input  Grant,
    input  Grant_idx,
    input  Grant_vld,
    input  Expired
  );
endinterface

// File: rtl/rr_arb8_ctrl.sv
// Eight-way round-robin arbiter with registered one-hot grant and an optional
// per-tenure hold limit. Every tenure is followed by one idle cycle.
module rr_arb8_ctrl #(
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  rr_arb8_ctrl_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] LAST_HOLD = 8'(MAX_HOLD - 1);
  localparam bit         LIMIT_ON  = (MAX_HOLD != 0);

  state_t     state, state_n;
  logic [2:0] ptr, ptr_n;
  logic [7:0] hold_cnt, hold_n;
  logic [7:0] grant, grant_n;
  logic [2:0] idx, idx_n;
  logic       vld, vld_n;
  logic       expired, expired_n;

  logic [2:0] winner;
  logic [2:0] cand;
  logic       found;
  logic       end_done, end_drop, end_limit;

  // First requester at or after ptr, wrapping 7 -> 0.
  always_comb begin
    winner = ptr;
    cand   = ptr;
    found  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!found && bus.Req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign end_done  = bus.Done;
  assign end_drop  = !bus.Req[idx];
  assign end_limit = LIMIT_ON && (hold_cnt == LAST_HOLD);

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    grant_n   = grant;
    idx_n     = idx;
    vld_n     = vld;
    expired_n = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          idx_n   = winner;
          grant_n = 8'b1 << winner;
          vld_n   = 1'b1;
          hold_n  = 8'd0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (end_done || end_drop || end_limit) begin
          // Expired flags only tenures cut short purely by the hold limit.
          grant_n   = 8'h00;
          vld_n     = 1'b0;
          ptr_n     = idx + 3'd1;
          expired_n = end_limit && !end_done && !end_drop;
          state_n   = IDLE;
        end else begin
          hold_n = hold_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      hold_cnt <= 8'd0;
      grant    <= 8'h00;
      idx      <= 3'd0;
      vld      <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      grant    <= grant_n;
      idx      <= idx_n;
      vld      <= vld_n;
      expired  <= expired_n;
    end
  end

  assign bus.Grant     = grant;
  assign bus.Grant_idx = idx;
  assign bus.Grant_vld = vld;
  assign bus.Expired   = expired;

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Directed bench for rr_arb8_ctrl: a vector table for arbitration order plus
// hand sequences for hold-limit, collision, drop and reset corner cases.
module tb_rr_arb8_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  rr_arb8_ctrl_if bus ();
  rr_arb8_ctrl_if bus_nolim ();

  rr_arb8_ctrl #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  rr_arb8_ctrl #(.MAX_HOLD(0)) dut_nolim (
    .clk (clk),
    .rst (rst),
    .bus (bus_nolim.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] idx;
    logic       vld;
    logic       expired;
  } vec_t;

  vec_t vecs [15];

  task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] grant, input logic [2:0] idx,
                             input logic vld, input logic expired);
    compare({name, ".grant"},   bus.Grant, grant);
    compare({name, ".idx"},     8'(bus.Grant_idx), 8'(idx));
    compare({name, ".vld"},     8'(bus.Grant_vld), 8'(vld));
    compare({name, ".expired"}, 8'(bus.Expired), 8'(expired));
  endtask

  // Drive inputs, then advance one rising edge and settle just after it.
  task automatic applyStimulus(input logic [7:0] req, input logic done);
    bus.Req  = req;
    bus.Done = done;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad_cycles;
    logic [2:0] k_idx;

    vecs[0]  = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
    vecs[1]  = '{8'h08, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0};
    vecs[2]  = '{8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0};
    vecs[3]  = '{8'h18, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[4]  = '{8'h18, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0};
    vecs[5]  = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[6]  = '{8'h20, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0};
    vecs[7]  = '{8'h21, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[8]  = '{8'h21, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[9]  = '{8'h21, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[10] = '{8'h21, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0};
    vecs[11] = '{8'hFF, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0};
    vecs[12] = '{8'hFF, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0};
    vecs[13] = '{8'hFF, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
    vecs[14] = '{8'hFF, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0};

    bus.Req = 8'h00;
    bus.Done = 1'b0;
    bus_nolim.Req = 8'h00;
    bus_nolim.Done = 1'b0;

    #1 rst = 1'b1;
    #2;
    checkOutput("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int v = 0; v < 15; v++) begin
      applyStimulus(vecs[v].req, vecs[v].done);
      checkOutput($sformatf("vec%0d", v), vecs[v].grant, vecs[v].idx, vecs[v].vld, vecs[v].expired);
    end

    // Full rotation starting at Ptr=0, wrapping past 7.
    for (int k = 0; k < 9; k++) begin
      k_idx = 3'(k % 8);
      applyStimulus(8'hFF, 1'b0);
      checkOutput($sformatf("rot%0d_grant", k), 8'b1 << k_idx, k_idx, 1'b1, 1'b0);
      applyStimulus(8'hFF, 1'b1);
      checkOutput($sformatf("rot%0d_gap", k), 8'h00, k_idx, 1'b0, 1'b0);
    end

    // Hold limit of 4 cycles, then a one-cycle Expired gap and a re-grant.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(8'h02, 1'b0);
      checkOutput($sformatf("hold%0d", c), 8'h02, 3'd1, 1'b1, 1'b0);
    end
    applyStimulus(8'h02, 1'b0);
    checkOutput("hold_expire", 8'h00, 3'd1, 1'b0, 1'b1);
    applyStimulus(8'h02, 1'b0);
    checkOutput("hold_regrant", 8'h02, 3'd1, 1'b1, 1'b0);

    // Done in the 4th cycle collides with the limit: no Expired.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(8'h02, 1'b0);
      checkOutput($sformatf("coll_done%0d", c), 8'h02, 3'd1, 1'b1, 1'b0);
    end
    applyStimulus(8'h02, 1'b1);
    checkOutput("coll_done_rel", 8'h00, 3'd1, 1'b0, 1'b0);

    // Request drop in the 4th cycle collides with the limit: no Expired.
    applyStimulus(8'h02, 1'b0);
    checkOutput("coll_drop_grant", 8'h02, 3'd1, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(8'h02, 1'b0);
      checkOutput($sformatf("coll_drop%0d", c), 8'h02, 3'd1, 1'b1, 1'b0);
    end
    applyStimulus(8'h00, 1'b0);
    checkOutput("coll_drop_rel", 8'h00, 3'd1, 1'b0, 1'b0);

    // Mid-tenure drop; non-owner bit changes are ignored.
    applyStimulus(8'h04, 1'b0);
    checkOutput("drop_grant", 8'h04, 3'd2, 1'b1, 1'b0);
    applyStimulus(8'h0C, 1'b0);
    checkOutput("drop_other", 8'h04, 3'd2, 1'b1, 1'b0);
    applyStimulus(8'h08, 1'b0);
    checkOutput("drop_rel", 8'h00, 3'd2, 1'b0, 1'b0);
    applyStimulus(8'h08, 1'b0);
    checkOutput("drop_next", 8'h08, 3'd3, 1'b1, 1'b0);

    // Asynchronous reset mid-tenure, then arbitration from Ptr=0.
    bus.Req = 8'h08;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_held", 8'h00, 3'd0, 1'b0, 1'b0);
    applyStimulus(8'h81, 1'b0);
    checkOutput("rst_restart", 8'h01, 3'd0, 1'b1, 1'b0);

    // MAX_HOLD=0: a held request is never released.
    bus_nolim.Req = 8'h01;
    @(posedge clk);
    #1;
    compare("nolim_grant", bus_nolim.Grant, 8'h01);
    bad_cycles = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (bus_nolim.Grant !== 8'h01 || bus_nolim.Expired !== 1'b0) bad_cycles++;
    end
    compare("nolim_bad_cycles", 8'(bad_cycles), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
